// File: rtl/noncache_arb.sv
// Two-requester arbiter for the noncacheable access path: round-robin grant, alignment check,
// single outstanding downstream access, and flush-driven response dropping.
module noncache_arb #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            m_req_vld,
    output logic [1:0]            m_req_rdy,
    input  logic [2*ADDR_W-1:0]   m_req_addr,
    input  logic [7:0]            m_req_len,
    input  logic [1:0]            m_req_store,
    input  logic [2*DATA_W-1:0]   m_req_data,
    output logic [1:0]            m_resp_vld,
    output logic [7:0]            m_resp_expt,
    output logic [DATA_W-1:0]     m_resp_data,
    input  logic                  noncache_req_rdy,
    output logic                  noncache_req_vld,
    output logic [ADDR_W-1:0]     noncache_req_addr,
    output logic [3:0]            noncache_req_len,
    output logic                  noncache_req_store,
    output logic [DATA_W-1:0]     noncache_req_data,
    output logic                  noncache_resp_rdy,
    input  logic                  noncache_resp_vld,
    input  logic [7:0]            noncache_resp_expt,
    input  logic [DATA_W-1:0]     noncache_resp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    localparam logic [7:0] EXPT_MISALIGN = 8'd2;

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic                drop_q, drop_d;
    logic                owner_q, owner_d;
    logic                req_vld_q, req_vld_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [3:0]          req_len_q, req_len_d;
    logic                req_store_q, req_store_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic [1:0]          resp_vld_q, resp_vld_d;
    logic [7:0]          resp_expt_q, resp_expt_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic [1:0]          grant;
    logic                gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [3:0]          sel_len;
    logic                sel_store;
    logic [DATA_W-1:0]   sel_data;
    logic                len_ok;
    logic                misalign;

    // Grant is combinational so a requester is accepted in the same cycle it is granted;
    // it is forced low while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (rst && (state_q == IDLE) && !flush) begin
            case (m_req_vld)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_idx   = grant[1];
    assign sel_addr  = gnt_idx ? m_req_addr[2*ADDR_W-1:ADDR_W] : m_req_addr[ADDR_W-1:0];
    assign sel_len   = gnt_idx ? m_req_len[7:4] : m_req_len[3:0];
    assign sel_store = m_req_store[gnt_idx];
    assign sel_data  = gnt_idx ? m_req_data[2*DATA_W-1:DATA_W] : m_req_data[DATA_W-1:0];

    assign len_ok   = (sel_len != 4'd0) && ((sel_len & (sel_len - 4'd1)) == 4'd0);
    assign misalign = (sel_len[1] & sel_addr[0]) | (sel_len[2] & (|sel_addr[1:0]))
                    | (sel_len[3] & (|sel_addr[2:0]));

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        drop_d      = drop_q;
        owner_d     = owner_q;
        req_vld_d   = req_vld_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        req_store_d = req_store_q;
        req_data_d  = req_data_q;
        resp_vld_d  = 2'b00;
        resp_expt_d = 8'd0;
        resp_data_d = '0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    rr_d = ~gnt_idx;
                    if (len_ok && !misalign) begin
                        req_vld_d   = 1'b1;
                        req_addr_d  = sel_addr;
                        req_len_d   = sel_len;
                        req_store_d = sel_store;
                        req_data_d  = sel_data;
                        owner_d     = gnt_idx;
                        state_d     = ISSUE;
                    end else begin
                        resp_vld_d  = grant;
                        resp_expt_d = EXPT_MISALIGN;
                    end
                end
            end
            ISSUE: begin
                if (flush) drop_d = 1'b1;
                if (noncache_req_rdy) begin
                    req_vld_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (flush) drop_d = 1'b1;
                if (noncache_resp_vld) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    // A flush arriving with the response drops it just like an earlier one.
                    if (!drop_q && !flush) begin
                        resp_vld_d  = owner_q ? 2'b10 : 2'b01;
                        resp_expt_d = noncache_resp_expt;
                        resp_data_d = req_store_q ? '0 : noncache_resp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            drop_q      <= 1'b0;
            owner_q     <= 1'b0;
            req_vld_q   <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= 4'd0;
            req_store_q <= 1'b0;
            req_data_q  <= '0;
            resp_vld_q  <= 2'b00;
            resp_expt_q <= 8'd0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            drop_q      <= drop_d;
            owner_q     <= owner_d;
            req_vld_q   <= req_vld_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_store_q <= req_store_d;
            req_data_q  <= req_data_d;
            resp_vld_q  <= resp_vld_d;
            resp_expt_q <= resp_expt_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign m_req_rdy          = grant;
    assign m_resp_vld         = resp_vld_q;
    assign m_resp_expt        = resp_expt_q;
    assign m_resp_data        = resp_data_q;
    assign noncache_req_vld   = req_vld_q;
    assign noncache_req_addr  = req_addr_q;
    assign noncache_req_len   = req_len_q;
    assign noncache_req_store = req_store_q;
    assign noncache_req_data  = req_data_q;
    assign noncache_resp_rdy  = (state_q == WAIT);

endmodule

// File: tb/tb_noncache_arb.sv
// Self-checking bench for noncache_arb: expected responses are queued as stimulus is driven
// and matched by a monitor whenever the arbiter strobes m_resp_vld.
module tb_noncache_arb;

    localparam int AW = 48;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        m_req_vld = 2'b00;
    logic [2*AW-1:0]   m_req_addr = '0;
    logic [7:0]        m_req_len = 8'd0;
    logic [1:0]        m_req_store = 2'b00;
    logic [2*DW-1:0]   m_req_data = '0;
    logic              noncache_req_rdy = 1'b0;
    logic              noncache_resp_vld = 1'b0;
    logic [7:0]        noncache_resp_expt = 8'd0;
    logic [DW-1:0]     noncache_resp_data = '0;

    logic [1:0]        m_req_rdy;
    logic [1:0]        m_resp_vld;
    logic [7:0]        m_resp_expt;
    logic [DW-1:0]     m_resp_data;
    logic              noncache_req_vld;
    logic [AW-1:0]     noncache_req_addr;
    logic [3:0]        noncache_req_len;
    logic              noncache_req_store;
    logic [DW-1:0]     noncache_req_data;
    logic              noncache_resp_rdy;

    typedef struct packed {
        logic [1:0]    vld;
        logic [7:0]    expt;
        logic [DW-1:0] data;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    noncache_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .m_req_vld          (m_req_vld),
        .m_req_rdy          (m_req_rdy),
        .m_req_addr         (m_req_addr),
        .m_req_len          (m_req_len),
        .m_req_store        (m_req_store),
        .m_req_data         (m_req_data),
        .m_resp_vld         (m_resp_vld),
        .m_resp_expt        (m_resp_expt),
        .m_resp_data        (m_resp_data),
        .noncache_req_rdy   (noncache_req_rdy),
        .noncache_req_vld   (noncache_req_vld),
        .noncache_req_addr  (noncache_req_addr),
        .noncache_req_len   (noncache_req_len),
        .noncache_req_store (noncache_req_store),
        .noncache_req_data  (noncache_req_data),
        .noncache_resp_rdy  (noncache_resp_rdy),
        .noncache_resp_vld  (noncache_resp_vld),
        .noncache_resp_expt (noncache_resp_expt),
        .noncache_resp_data (noncache_resp_data)
    );

    always #5 clk = ~clk;

    // Response monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m_resp_vld !== 2'b00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL resp_unexpected: got vld=%b expt=%0d data=%h, expected no response",
                         m_resp_vld, m_resp_expt, m_resp_data);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                if ({m_resp_vld, m_resp_expt, m_resp_data} !== e) begin
                    n_fails++;
                    $display("FAIL resp_match: got vld=%b expt=%0d data=%h, expected vld=%b expt=%0d data=%h",
                             m_resp_vld, m_resp_expt, m_resp_data, e.vld, e.expt, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [3:0] len,
                           input logic st, input logic [DW-1:0] d);
        if (idx == 0) begin
            m_req_addr[AW-1:0] = addr;
            m_req_len[3:0]     = len;
            m_req_store[0]     = st;
            m_req_data[DW-1:0] = d;
        end else begin
            m_req_addr[2*AW-1:AW] = addr;
            m_req_len[7:4]        = len;
            m_req_store[1]        = st;
            m_req_data[2*DW-1:DW] = d;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        m_req_vld = 2'b11;
        noncache_req_rdy = 1'b1;
        noncache_resp_vld = 1'b1;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b00) begin
            n_fails++;
            $display("FAIL reset_req_rdy: got %b expected 00", m_req_rdy);
        end
        n_checks++;
        if ({m_resp_vld, m_resp_expt, m_resp_data} !== '0) begin
            n_fails++;
            $display("FAIL reset_resp: got vld=%b expt=%0d data=%h expected all 0",
                     m_resp_vld, m_resp_expt, m_resp_data);
        end
        n_checks++;
        if ({noncache_req_vld, noncache_req_addr, noncache_req_len, noncache_req_store,
             noncache_req_data, noncache_resp_rdy} !== '0) begin
            n_fails++;
            $display("FAIL reset_downstream: got vld=%b addr=%h len=%b st=%b data=%h resp_rdy=%b expected all 0",
                     noncache_req_vld, noncache_req_addr, noncache_req_len, noncache_req_store,
                     noncache_req_data, noncache_resp_rdy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [1:0]    exp_g;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] d;
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        set_req(0, 48'h0000_0000_0100, 4'b1000, 1'b0, '0);
        set_req(1, 48'h0000_0000_0200, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b11;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_g    = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 48'h0000_0000_0100 : 48'h0000_0000_0200;
            n_checks++;
            if (m_req_rdy !== exp_g) begin
                n_fails++;
                $display("FAIL rr_grant_%0d: got %b expected %b", k, m_req_rdy, exp_g);
            end
            @(negedge clk);
            n_checks++;
            if (noncache_req_vld !== 1'b1 || noncache_req_addr !== exp_addr) begin
                n_fails++;
                $display("FAIL rr_issue_%0d: got vld=%b addr=%h expected vld=1 addr=%h",
                         k, noncache_req_vld, noncache_req_addr, exp_addr);
            end
            @(negedge clk);
            d = 64'h0000_0000_0000_1000 + 64'(k);
            noncache_resp_vld  = 1'b1;
            noncache_resp_data = d;
            exp_q.push_back({exp_g, 8'd0, d});
            @(negedge clk);
            noncache_resp_vld = 1'b0;
            #1;
        end
        m_req_vld = 2'b00;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL rr_drain: got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    task automatic test_single_load;
        @(negedge clk);
        set_req(0, 48'h0000_8000_0010, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b01;
        noncache_req_rdy = 1'b1;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b01) begin
            n_fails++;
            $display("FAIL load_grant: got %b expected 01", m_req_rdy);
        end
        @(negedge clk);
        m_req_vld = 2'b00;
        n_checks++;
        if (noncache_req_vld !== 1'b1 || noncache_req_addr !== 48'h0000_8000_0010 ||
            noncache_req_len !== 4'b1000 || noncache_req_store !== 1'b0 || noncache_resp_rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL load_issue: got vld=%b addr=%h len=%b st=%b resp_rdy=%b expected 1/000080000010/1000/0/0",
                     noncache_req_vld, noncache_req_addr, noncache_req_len, noncache_req_store, noncache_resp_rdy);
        end
        @(negedge clk);
        n_checks++;
        if (noncache_req_vld !== 1'b0 || noncache_resp_rdy !== 1'b1) begin
            n_fails++;
            $display("FAIL load_wait: got req_vld=%b resp_rdy=%b expected 0/1", noncache_req_vld, noncache_resp_rdy);
        end
        @(negedge clk);
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'hDEAD_BEEF_0123_4567;
        exp_q.push_back({2'b01, 8'd0, 64'hDEAD_BEEF_0123_4567});
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL load_resp_seen: got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    task automatic test_misaligned;
        logic [AW-1:0] addrs [4];
        logic [3:0]    lens  [4];
        int            who   [4];
        addrs = '{48'h0000_1234_0003, 48'h0000_0000_0000, 48'h0000_0000_0001, 48'h0000_0000_0006};
        lens  = '{4'b0100, 4'b0011, 4'b0010, 4'b0010};
        who   = '{1, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_req(who[k], addrs[k], lens[k], 1'b0, '0);
            m_req_vld = (who[k] == 1) ? 2'b10 : 2'b01;
            #1;
            n_checks++;
            if (m_req_rdy !== m_req_vld) begin
                n_fails++;
                $display("FAIL misalign_grant_%0d: got %b expected %b", k, m_req_rdy, m_req_vld);
            end
            exp_q.push_back({m_req_vld, 8'd2, 64'd0});
            @(negedge clk);
            m_req_vld = 2'b00;
            #1;
            n_checks++;
            if (noncache_req_vld !== 1'b0 || exp_q.size() != 0) begin
                n_fails++;
                $display("FAIL misalign_%0d: got req_vld=%b pending=%0d expected 0/0",
                         k, noncache_req_vld, exp_q.size());
            end
        end
        // 2-byte access on an even address is legal and goes downstream.
        @(negedge clk);
        set_req(0, addrs[3], lens[3], 1'b0, '0);
        m_req_vld = 2'b01;
        @(negedge clk);
        m_req_vld = 2'b00;
        n_checks++;
        if (noncache_req_vld !== 1'b1 || noncache_req_len !== 4'b0010) begin
            n_fails++;
            $display("FAIL aligned_2b_issue: got vld=%b len=%b expected 1/0010", noncache_req_vld, noncache_req_len);
        end
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_BEEF;
        exp_q.push_back({2'b01, 8'd0, 64'h0000_0000_0000_BEEF});
        @(negedge clk);
        noncache_resp_vld = 1'b0;
    endtask

    task automatic test_flush_wait;
        @(negedge clk);
        flush = 1'b1;
        set_req(0, 48'h0000_0000_0100, 4'b0100, 1'b1, 64'h1122_3344_5566_7788);
        m_req_vld = 2'b01;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b00) begin
            n_fails++;
            $display("FAIL flush_blocks_grant: got %b expected 00", m_req_rdy);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b01) begin
            n_fails++;
            $display("FAIL flush_wait_grant: got %b expected 01", m_req_rdy);
        end
        @(negedge clk);
        m_req_vld = 2'b00;
        n_checks++;
        if (noncache_req_store !== 1'b1 || noncache_req_data !== 64'h1122_3344_5566_7788) begin
            n_fails++;
            $display("FAIL store_issue: got st=%b data=%h expected 1/1122334455667788",
                     noncache_req_store, noncache_req_data);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_AAAA;
        #1;
        n_checks++;
        if (noncache_resp_rdy !== 1'b1) begin
            n_fails++;
            $display("FAIL flush_wait_resp_rdy: got %b expected 1", noncache_resp_rdy);
        end
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        n_checks++;
        if (m_resp_vld !== 2'b00 || noncache_resp_rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_wait_dropped: got resp_vld=%b resp_rdy=%b expected 00/0", m_resp_vld, noncache_resp_rdy);
        end
        // Flush coincident with the downstream response.
        set_req(0, 48'h0000_0000_0108, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b01;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b01) begin
            n_fails++;
            $display("FAIL after_flush_grant: got %b expected 01", m_req_rdy);
        end
        @(negedge clk);
        m_req_vld = 2'b00;
        @(negedge clk);
        flush = 1'b1;
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_BBBB;
        @(negedge clk);
        flush = 1'b0;
        noncache_resp_vld = 1'b0;
        n_checks++;
        if (m_resp_vld !== 2'b00 || noncache_resp_rdy !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_coincident: got resp_vld=%b resp_rdy=%b expected 00/0", m_resp_vld, noncache_resp_rdy);
        end
        // Store response returns zero data even if downstream drives data.
        set_req(0, 48'h0000_0000_0110, 4'b1000, 1'b1, 64'h55);
        m_req_vld = 2'b01;
        @(negedge clk);
        m_req_vld = 2'b00;
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_CAFE;
        exp_q.push_back({2'b01, 8'd0, 64'd0});
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL store_resp_seen: got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    task automatic test_flush_issue;
        noncache_req_rdy = 1'b0;
        @(negedge clk);
        set_req(1, 48'h0000_0000_0040, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b10;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b10) begin
            n_fails++;
            $display("FAIL flush_issue_grant: got %b expected 10", m_req_rdy);
        end
        @(negedge clk);
        m_req_vld = 2'b00;
        flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            flush = 1'b0;
            n_checks++;
            if (noncache_req_vld !== 1'b1 || noncache_req_addr !== 48'h0000_0000_0040 || noncache_req_len !== 4'b1000) begin
                n_fails++;
                $display("FAIL issue_hold_%0d: got vld=%b addr=%h len=%b expected 1/000000000040/1000",
                         c, noncache_req_vld, noncache_req_addr, noncache_req_len);
            end
        end
        noncache_req_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (noncache_req_vld !== 1'b0 || noncache_resp_rdy !== 1'b1) begin
            n_fails++;
            $display("FAIL issue_handshake: got req_vld=%b resp_rdy=%b expected 0/1", noncache_req_vld, noncache_resp_rdy);
        end
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_DDDD;
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        n_checks++;
        if (m_resp_vld !== 2'b00) begin
            n_fails++;
            $display("FAIL flush_issue_dropped: got %b expected 00", m_resp_vld);
        end
        // A stray downstream response in IDLE is ignored.
        noncache_resp_vld = 1'b1;
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_resp_vld !== 2'b00 || noncache_req_vld !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_resp_ignored: got resp_vld=%b req_vld=%b expected 00/0", m_resp_vld, noncache_req_vld);
        end
    endtask

    task automatic test_downstream_error;
        @(negedge clk);
        set_req(0, 48'h0000_0000_0200, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b01;
        @(negedge clk);
        m_req_vld = 2'b00;
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_expt = 8'd1;
        noncache_resp_data = 64'h0000_0000_0000_0BAD;
        exp_q.push_back({2'b01, 8'd1, 64'h0000_0000_0000_0BAD});
        @(negedge clk);
        noncache_resp_vld  = 1'b0;
        noncache_resp_expt = 8'd0;
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL error_resp_seen: got %0d pending responses expected 0", exp_q.size());
        end
        // Reset asserted while the access waits for its response.
        set_req(0, 48'h0000_0000_0208, 4'b1000, 1'b0, '0);
        m_req_vld = 2'b01;
        @(negedge clk);
        m_req_vld = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_EEEE;
        #1;
        n_checks++;
        if ({m_req_rdy, m_resp_vld, m_resp_expt, m_resp_data, noncache_req_vld, noncache_req_addr,
             noncache_req_len, noncache_req_store, noncache_req_data, noncache_resp_rdy} !== '0) begin
            n_fails++;
            $display("FAIL reset_in_wait: got req_vld=%b addr=%h resp_rdy=%b resp_vld=%b expected all outputs 0",
                     noncache_req_vld, noncache_req_addr, noncache_resp_rdy, m_resp_vld);
        end
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        m_req_vld = 2'b11;
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_req_rdy !== 2'b01) begin
            n_fails++;
            $display("FAIL post_reset_grant: got %b expected 01", m_req_rdy);
        end
        @(negedge clk);
        m_req_vld = 2'b00;
        n_checks++;
        if (noncache_req_vld !== 1'b1 || m_resp_vld !== 2'b00) begin
            n_fails++;
            $display("FAIL post_reset_issue: got req_vld=%b resp_vld=%b expected 1/00", noncache_req_vld, m_resp_vld);
        end
        @(negedge clk);
        noncache_resp_vld  = 1'b1;
        noncache_resp_data = 64'h0000_0000_0000_0077;
        exp_q.push_back({2'b01, 8'd0, 64'h0000_0000_0000_0077});
        @(negedge clk);
        noncache_resp_vld = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL post_reset_resp_seen: got %0d pending responses expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_single_load;
        test_misaligned;
        test_flush_wait;
        test_flush_issue;
        test_downstream_error;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
